// File: rtl/seg_capture.sv
// seg_capture: readback decoder for the multiplexed common-anode 7-segment bus.
//
// Both `an` (digit enables) and `dsp` (segment lines) are active-low and pass
// through 2-flop synchronizers. A pattern that selects exactly one position has
// to stay unchanged for STABLE_CNT synchronized cycles before it is committed.
// On commit, the pattern is decoded into a 4-bit digit for that position.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   an[3:0]      digit enables, active-low, bit i selects position i
//   dsp[6:0]     segment lines, active-low, bit0=a .. bit6=g
//   digits[15:0] decoded values, position i at [4i+3:4i]
//   dig_valid    position holds a committed valid decode
//   dig_err      last committed pattern at the position was undecodable
//   upd/upd_idx  one-cycle pulse when a stored value changes, plus its position

// Storage for a single display position. A write either stores a decoded
// value or flags an error and leaves the digit untouched.
module seg_capture_pos (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       ok,
  input  logic [3:0] val,
  output logic [3:0] digit,
  output logic       valid,
  output logic       err,
  output logic       changed
);
  // Only a valid write that actually alters the visible value counts as an update.
  assign changed = wr && ok && (!valid || digit != val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (wr) begin
      if (ok) begin
        digit <= val;
        valid <= 1'b1;
        err   <= 1'b0;
      end else begin
        valid <= 1'b0;
        err   <= 1'b1;
      end
    end
  end
endmodule

module seg_capture #(
  parameter int STABLE_CNT = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  dsp,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic [3:0]  dig_err,
  output logic        upd,
  output logic [1:0]  upd_idx
);
  localparam int NUM_POS = 4;

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT, HOLD} state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } dec_t;

  // Maps a segment pattern to a digit; anything outside the table is invalid.
  function automatic dec_t decode(input logic [6:0] s);
    dec_t d;
    d.ok  = 1'b1;
    d.val = 4'h0;
    case (s)
      7'h40: d.val = 4'h0;
      7'h79: d.val = 4'h1;
      7'h24: d.val = 4'h2;
      7'h30: d.val = 4'h3;
      7'h19: d.val = 4'h4;
      7'h12: d.val = 4'h5;
      7'h02: d.val = 4'h6;
      7'h78: d.val = 4'h7;
      7'h00: d.val = 4'h8;
      7'h10: d.val = 4'h9;
      7'h01: d.val = 4'hF;  // overrange marker
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

  // ---- input synchronizers ----
  logic [3:0] an_m, an_s;
  logic [6:0] dsp_m, dsp_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m  <= '0;
      an_s  <= '0;
      dsp_m <= '0;
      dsp_s <= '0;
    end else begin
      an_m  <= an;
      an_s  <= an_m;
      dsp_m <= dsp;
      dsp_s <= dsp_m;
    end
  end

  // ---- select / match ----
  logic [3:0]       an_low;
  logic             sel;
  logic [3:0]       ref_an;
  logic [6:0]       ref_seg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             same;
  logic             done;

  // Exactly one low enable means a nonzero power of two after inversion.
  assign an_low  = ~an_s;
  assign sel     = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
  assign same    = (an_s == ref_an) && (dsp_s == ref_seg);
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign done    = (cnt_inc == (CNT_W+1)'(STABLE_CNT));

  // ---- FSM: state register ----
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (sel) state_nxt = TRACK;
      TRACK: begin
        if (!sel)             state_nxt = IDLE;
        else if (same && done) state_nxt = COMMIT;
        else                  state_nxt = TRACK;
      end
      COMMIT: state_nxt = HOLD;
      HOLD: begin
        if (same)     state_nxt = HOLD;
        else if (sel) state_nxt = TRACK;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  logic commit;
  logic load;
  logic inc;

  always_comb begin
    commit = 1'b0;
    load   = 1'b0;
    inc    = 1'b0;
    case (state)
      IDLE:   load = sel;
      TRACK: begin
        load = sel && !same;
        inc  = sel && same;
      end
      COMMIT: commit = 1'b1;
      HOLD:   load = sel && !same;
      default: ;
    endcase
  end

  // ---- reference pattern and stability counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_an  <= '0;
      ref_seg <= '0;
      cnt     <= '0;
    end else if (load) begin
      ref_an  <= an_s;
      ref_seg <= dsp_s;
      cnt     <= CNT_W'(1);
    end else if (inc && !(&cnt)) begin
      cnt <= cnt_inc[CNT_W-1:0];  // saturates at all-ones
    end
  end

  // ---- commit datapath ----
  logic [1:0] pidx;
  dec_t       dec;

  always_comb begin
    pidx = '0;
    for (int i = 0; i < NUM_POS; i++)
      if (!ref_an[i]) pidx = 2'(i);
  end

  assign dec = decode(ref_seg);

  logic [NUM_POS-1:0][3:0] dig_arr;
  logic [NUM_POS-1:0]      chg;

  for (genvar g = 0; g < NUM_POS; g++) begin : g_pos
    seg_capture_pos u_pos (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (commit && !ref_an[g]),
      .ok      (dec.ok),
      .val     (dec.val),
      .digit   (dig_arr[g]),
      .valid   (dig_valid[g]),
      .err     (dig_err[g]),
      .changed (chg[g])
    );
  end

  assign digits = dig_arr;

  // ---- update strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd     <= 1'b0;
      upd_idx <= '0;
    end else begin
      upd <= |chg;
      if (|chg) upd_idx <= pidx;
    end
  end
endmodule

// File: tb/tb_seg_capture.sv
module tb_seg_capture;
  localparam int SC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  dsp;
  logic [15:0] digits;
  logic [3:0]  dig_valid, dig_err;
  logic        upd;
  logic [1:0]  upd_idx;

  seg_capture #(.STABLE_CNT(SC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .dsp(dsp), .digits(digits),
    .dig_valid(dig_valid), .dig_err(dig_err), .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int idx; int val; } exp_t;
  exp_t q[$];

  // reference model: per-position contents implied by the sequence of held patterns
  int m_dig[4];
  bit m_val[4];
  bit m_err[4];
  int m_last_idx;
  logic [3:0] prev_a;
  logic [6:0] prev_d;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dec(logic [6:0] s);
    case (s)
      7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
      7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
      7'h00: return 8;  7'h10: return 9;  7'h01: return 15;
      default: return -1;
    endcase
  endfunction

  // index of the single low enable, or -1 when not exactly one is low
  function automatic int one_low(logic [3:0] a);
    int n = 0;
    int p = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  // A pattern held at least SC cycles commits to its position.
  function automatic void model(logic [3:0] a, logic [6:0] d, int len);
    int p = one_low(a);
    int v = dec(d);
    prev_a = a;
    prev_d = d;
    if (p < 0 || len < SC) return;
    if (v >= 0) begin
      if (!m_val[p] || m_dig[p] != v) begin
        q.push_back('{p, v});
        m_last_idx = p;
      end
      m_dig[p] = v;
      m_val[p] = 1'b1;
      m_err[p] = 1'b0;
    end else begin
      m_val[p] = 1'b0;
      m_err[p] = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_val[i] = 0; m_err[i] = 0; end
    m_last_idx = 0;
    q.delete();
  endfunction

  task automatic seg(logic [3:0] a, logic [6:0] d, int len);
    model(a, d, len);
    an  = a;
    dsp = d;
    repeat (len) @(negedge clk);
  endtask

  task automatic check_state(string tag);
    seg(4'hF, 7'h7F, 6);  // let any commit in flight land
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_digit"}, digits[4*i +: 4], m_dig[i]);
      chk({tag, "_valid"}, dig_valid[i], m_val[i]);
      chk({tag, "_err"}, dig_err[i], m_err[i]);
    end
    chk({tag, "_upd_idx"}, upd_idx, m_last_idx);
    chk({tag, "_pending"}, q.size(), 0);
  endtask

  // monitor: every upd pulse must match the next expected update
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && upd === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_upd: got idx %0d digits %0h expected no update", upd_idx, digits);
        end else begin
          e = q.pop_front();
          chk("upd_idx", upd_idx, e.idx);
          chk("upd_digit", digits[4*e.idx +: 4], e.val);
        end
      end
    end
  end

  logic [6:0] codes [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h01};

  initial begin
    logic [3:0] a;
    logic [6:0] d;
    int len;
    rst_n = 1'b0;
    an    = 4'hF;
    dsp   = 7'h7F;
    model_clear();
    prev_a = 4'hF;
    prev_d = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_digits", digits, 0);
    chk("rst_valid", dig_valid, 0);
    chk("rst_err", dig_err, 0);
    chk("rst_upd", upd, 0);
    chk("rst_upd_idx", upd_idx, 0);
    rst_n = 1'b1;

    // first commit latency: pulse lands after the 19th edge, for one cycle
    model(4'hE, 7'h24, 20);
    an  = 4'hE;
    dsp = 7'h24;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 18) chk("lat_early", upd, 0);
      if (i == 19) begin
        chk("lat_upd", upd, 1);
        chk("lat_digit", digits[3:0], 2);
        chk("lat_valid", dig_valid, 4'b0001);
      end
      if (i == 20) chk("lat_pulse_width", upd, 0);
    end

    seg(4'hE, 7'h24, 200);  // same value again: no further update
    seg(4'hE, 7'h30, 20);
    check_state("hold_then_change");

    seg(4'hE, 7'h10, 20);
    seg(4'hD, 7'h40, 20);
    seg(4'hB, 7'h78, 20);
    seg(4'h7, 7'h01, 20);
    check_state("scan");
    chk("scan_digits", digits, 16'hF709);

    for (int i = 0; i < 6; i++) seg(4'hD, (i % 2) ? 7'h02 : 7'h00, 8);
    seg(4'hD, 7'h02, 20);
    check_state("glitch");

    seg(4'hB, 7'h7F, 20);
    check_state("invalid");
    seg(4'hB, 7'h79, 20);
    check_state("recover");

    seg(4'hC, 7'h12, 50);
    seg(4'hF, 7'h19, 50);
    check_state("noselect");

    // reset in the middle of tracking
    seg(4'h7, 7'h19, 8);
    #2;
    rst_n = 1'b0;
    an    = 4'hF;
    #1;
    chk("async_rst_digits", digits, 0);
    chk("async_rst_valid", dig_valid, 0);
    chk("async_rst_err", dig_err, 0);
    chk("async_rst_upd", upd, 0);
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seg(4'hF, 7'h7F, 30);
    check_state("after_reset");

    // randomized segments; lengths avoid the 15..17 boundary band
    for (int n = 0; n < 300; n++) begin
      do begin
        if ($urandom_range(3) != 0) a = ~(4'b1 << $urandom_range(3));
        else begin
          do a = 4'($urandom()); while (one_low(a) >= 0);
        end
        d = $urandom_range(1) ? codes[$urandom_range(10)] : 7'($urandom());
      end while ((one_low(a) < 0 && one_low(prev_a) < 0) || (a == prev_a && d == prev_d));
      len = ($urandom_range(2) == 0) ? int'($urandom_range(14, 1)) : int'($urandom_range(40, 18));
      seg(a, d, len);
      if (n % 50 == 49) check_state("random");
    end
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
